chime_sequencer: RTL and testbench

- Upstream stage of the buzzer path. Watches the running time-of-day and the alarm setting, and decides when to beep and how many times.
- Drives a gated beep-enable into the tone generator (buzz_en high = tone on).
- Two beep sources:
  - hourly chime: one beep per hour on a 12-hour face;
  - alarm: a fixed-length beep burst that the user can stop early.
- Replaces ad-hoc beep counting with one FSM that arbitrates both sources.

---
 rtl/chime_sequencer.sv | 165 ++++++++++++++++
 tb/tb_chime_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/chime_sequencer.sv
// chime_sequencer
//   Decides when the buzzer beeps and how many times. It watches the time of
//   day and the alarm setting and drives a registered beep enable into the
//   tone generator. Two sources share one IDLE/ON/GAP FSM:
//     - hourly chime: N = hour mod 12 beeps (0 shown as 12);
//     - alarm burst: ALARM_BEEPS beeps, which the stop key can cut short.
//   An alarm preempts a running chime. A chime never interrupts anything.
//   Optional build macro CHIME_QUIET_EN: suppresses chimes (never alarms)
//   while hour is inside [QUIET_START, QUIET_END), wrapping past midnight.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   sec_tick       one-cycle pulse: time registers just advanced
//   hour/minute/second       current time (binary)
//   alarm_hour/alarm_min     alarm setting, alarm_on = armed
//   stop           one-cycle pulse from the debounced stop key
//   buzz_en        registered beep enable (1 = tone on)
//   busy           a sequence is running
//   alarm_active   the running sequence is an alarm
//   beeps_left     beeps remaining, including the current one
module chime_sequencer #(
    parameter int ON_CYC      = 50000000,
    parameter int GAP_CYC     = 50000000,
    parameter int ALARM_BEEPS = 30,
    parameter int QUIET_START = 22,
    parameter int QUIET_END   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_on,
    input  logic       stop,
    output logic       buzz_en,
    output logic       busy,
    output logic       alarm_active,
    output logic [7:0] beeps_left
);

    localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [4:0] Q_START = 5'(QUIET_START);
    localparam logic [4:0] Q_END   = 5'(QUIET_END);

`ifdef CHIME_QUIET_EN
    localparam bit QUIET_EN = 1'b1;
`else
    localparam bit QUIET_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       beeps_q, beeps_d;
    logic             alarm_q, alarm_d;
    logic             buzz_q, buzz_d;
    logic             busy_q, busy_d;

    logic       in_range, in_quiet, chime_trig, alarm_trig;
    logic [4:0] hour12;
    logic [7:0] chime_n;

    always_comb begin
        in_range = (hour <= 5'd23) && (minute <= 6'd59) && (second <= 6'd59);
        // A start hour above the end hour means the window spans midnight.
        if (QUIET_START > QUIET_END)
            in_quiet = (hour >= Q_START) || (hour < Q_END);
        else
            in_quiet = (hour >= Q_START) && (hour < Q_END);
        chime_trig = sec_tick && in_range && (minute == 6'd0) && (second == 6'd0)
                     && !(QUIET_EN && in_quiet);
        alarm_trig = sec_tick && in_range && alarm_on && (hour == alarm_hour)
                     && (minute == alarm_min) && (second == 6'd0);
        hour12  = (hour >= 5'd12) ? (hour - 5'd12) : hour;
        chime_n = (hour12 == 5'd0) ? 8'd12 : {3'b000, hour12};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        beeps_d = beeps_q;
        alarm_d = alarm_q;
        // Priority: a fresh alarm (also over a chime), then a chime from IDLE,
        // then stop, then normal sequencing. A trigger that is taken thus
        // masks a simultaneous stop.
        if (alarm_trig && !alarm_q) begin
            state_d = ON;
            cnt_d   = '0;
            beeps_d = 8'(ALARM_BEEPS);
            alarm_d = 1'b1;
        end else if (chime_trig && (state_q == IDLE)) begin
            state_d = ON;
            cnt_d   = '0;
            beeps_d = chime_n;
            alarm_d = 1'b0;
        end else if (stop && alarm_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            beeps_d = 8'd0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (beeps_q > 8'd1) begin
                            beeps_d = beeps_q - 8'd1;
                            state_d = ON;
                        end else begin
                            beeps_d = 8'd0;
                            alarm_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    beeps_d = 8'd0;
                    alarm_d = 1'b0;
                end
            endcase
        end
        buzz_d = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beeps_q <= 8'd0;
            alarm_q <= 1'b0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beeps_q <= beeps_d;
            alarm_q <= alarm_d;
            buzz_q  <= buzz_d;
            busy_q  <= busy_d;
        end
    end

    assign buzz_en      = buzz_q;
    assign busy         = busy_q;
    assign alarm_active = alarm_q;
    assign beeps_left   = beeps_q;

endmodule

// File: tb/tb_chime_sequencer.sv
module tb_chime_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic [4:0] hour = 5'd0;
    logic [5:0] minute = 6'd1;
    logic [5:0] second = 6'd1;
    logic [4:0] alarm_hour = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic       alarm_on = 1'b0;
    logic       stop = 1'b0;
    logic       buzz_en, busy, alarm_active;
    logic [7:0] beeps_left;

    int pass_cnt = 0;
    int total_cnt = 0;

    chime_sequencer #(
        .ON_CYC(4), .GAP_CYC(3), .ALARM_BEEPS(5), .QUIET_START(22), .QUIET_END(7)
    ) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .hour(hour), .minute(minute),
        .second(second), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_on(alarm_on), .stop(stop), .buzz_en(buzz_en), .busy(busy),
        .alarm_active(alarm_active), .beeps_left(beeps_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [4:0] ah;
        logic [5:0] am;
        logic       aon;
        int         n;      // expected beeps, 0 = no response
        logic       alarm;  // expected alarm_active
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one tick with the given time/alarm inputs. Returns at the
    // negedge following the edge that sampled the tick (cycle t+1).
    task automatic fire(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                        input logic [4:0] ah, input logic [5:0] am, input logic aon);
        @(negedge clk);
        hour = h; minute = m; second = s;
        alarm_hour = ah; alarm_min = am; alarm_on = aon;
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    // Count busy and buzz-high cycles from the current sample until busy drops.
    task automatic measure(output int bc, output int hc);
        int guard;
        bc = 0; hc = 0; guard = 0;
        while (busy && guard < 200) begin
            bc++;
            if (buzz_en) hc++;
            guard++;
            @(negedge clk);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int bc, hc;

        vt[0]  = '{5'd15, 6'd0,  6'd0,  5'd0,  6'd0,  1'b0, 3,  1'b0};
        vt[1]  = '{5'd0,  6'd0,  6'd0,  5'd1,  6'd0,  1'b0, 12, 1'b0};
        vt[2]  = '{5'd12, 6'd0,  6'd0,  5'd1,  6'd0,  1'b0, 12, 1'b0};
        vt[3]  = '{5'd25, 6'd0,  6'd0,  5'd25, 6'd0,  1'b1, 0,  1'b0};
        vt[4]  = '{5'd7,  6'd30, 6'd0,  5'd7,  6'd30, 1'b1, 5,  1'b1};
        vt[5]  = '{5'd7,  6'd30, 6'd0,  5'd7,  6'd30, 1'b0, 0,  1'b0};
        vt[6]  = '{5'd8,  6'd0,  6'd0,  5'd8,  6'd0,  1'b1, 5,  1'b1};
        vt[7]  = '{5'd10, 6'd0,  6'd60, 5'd0,  6'd0,  1'b0, 0,  1'b0};
`ifdef CHIME_QUIET_EN
        vt[8]  = '{5'd23, 6'd0,  6'd0,  5'd0,  6'd0,  1'b0, 0,  1'b0};
`else
        vt[8]  = '{5'd23, 6'd0,  6'd0,  5'd0,  6'd0,  1'b0, 11, 1'b0};
`endif
        vt[9]  = '{5'd7,  6'd0,  6'd0,  5'd0,  6'd0,  1'b0, 7,  1'b0};
        vt[10] = '{5'd23, 6'd15, 6'd0,  5'd23, 6'd15, 1'b1, 5,  1'b1};
        vt[11] = '{5'd9,  6'd5,  6'd0,  5'd9,  6'd6,  1'b1, 0,  1'b0};

        // Reset state
        wait_cyc(3);
        check("rst_buzz", int'(buzz_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_alarm", int'(alarm_active), 0);
        check("rst_beeps", int'(beeps_left), 0);
        rst = 1'b0;
        wait_cyc(2);

        // Table-driven triggers
        for (int i = 0; i < 12; i++) begin
            fire(vt[i].h, vt[i].m, vt[i].s, vt[i].ah, vt[i].am, vt[i].aon);
            check($sformatf("v%0d_buzz_t1", i), int'(buzz_en), (vt[i].n > 0) ? 1 : 0);
            check($sformatf("v%0d_alarm", i), int'(alarm_active), int'(vt[i].alarm));
            if (vt[i].n > 0)
                check($sformatf("v%0d_beeps", i), int'(beeps_left), vt[i].n);
            measure(bc, hc);
            check($sformatf("v%0d_busy_cyc", i), bc, vt[i].n * 7);
            check($sformatf("v%0d_buzz_cyc", i), hc, vt[i].n * 4);
            check($sformatf("v%0d_alarm_end", i), int'(alarm_active), 0);
            wait_cyc(2);
        end

        // Exact waveform of a 3-beep chime
        fire(5'd15, 6'd0, 6'd0, 5'd0, 6'd0, 1'b0);
        check("w_c1_buzz", int'(buzz_en), 1);
        wait_cyc(3);
        check("w_c4_buzz", int'(buzz_en), 1);
        wait_cyc(1);
        check("w_c5_buzz", int'(buzz_en), 0);
        wait_cyc(2);
        check("w_c7_busy", int'(busy), 1);
        check("w_c7_buzz", int'(buzz_en), 0);
        wait_cyc(1);
        check("w_c8_buzz", int'(buzz_en), 1);
        check("w_c8_beeps", int'(beeps_left), 2);
        wait_cyc(7);
        check("w_c15_beeps", int'(beeps_left), 1);
        wait_cyc(6);
        check("w_c21_busy", int'(busy), 1);
        wait_cyc(1);
        check("w_c22_busy", int'(busy), 0);
        wait_cyc(2);

        // Stop in the second ON phase of an alarm
        fire(5'd7, 6'd30, 6'd0, 5'd7, 6'd30, 1'b1);
        wait_cyc(8);
        check("stop_pre_buzz", int'(buzz_en), 1);
        check("stop_pre_beeps", int'(beeps_left), 4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_buzz", int'(buzz_en), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_beeps", int'(beeps_left), 0);
        check("stop_alarm", int'(alarm_active), 0);
        wait_cyc(2);

        // Stop during a chime is ignored
        fire(5'd3, 6'd0, 6'd0, 5'd0, 6'd0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        measure(bc, hc);
        check("cstop_busy_cyc", bc, 20);
        check("cstop_buzz_cyc", hc, 11);
        wait_cyc(2);

        // Alarm preempts a running chime, then a repeat alarm tick is ignored
        fire(5'd10, 6'd0, 6'd0, 5'd0, 6'd0, 1'b0);
        check("pre_chime_beeps", int'(beeps_left), 10);
        wait_cyc(4);
        fire(5'd10, 6'd0, 6'd0, 5'd10, 6'd0, 1'b1);
        check("pre_buzz", int'(buzz_en), 1);
        check("pre_alarm", int'(alarm_active), 1);
        check("pre_beeps", int'(beeps_left), 5);
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        measure(bc, hc);
        check("pre_busy_cyc", bc, 34);
        check("pre_buzz_cyc", hc, 19);
        wait_cyc(2);

        // alarm_on dropping mid-burst does not abort it
        fire(5'd7, 6'd30, 6'd0, 5'd7, 6'd30, 1'b1);
        alarm_on = 1'b0;
        measure(bc, hc);
        check("aoff_busy_cyc", bc, 35);
        wait_cyc(2);

        // Reset in the middle of a GAP
        fire(5'd5, 6'd0, 6'd0, 5'd0, 6'd0, 1'b0);
        wait_cyc(4);
        check("rgap_buzz", int'(buzz_en), 0);
        check("rgap_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rgap_buzz0", int'(buzz_en), 0);
        check("rgap_busy0", int'(busy), 0);
        check("rgap_beeps0", int'(beeps_left), 0);
        check("rgap_alarm0", int'(alarm_active), 0);
        wait_cyc(3);
        check("rgap_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
